ls_dmem: RTL

Parametrised load/store data memory for the NPC core: accepts one byte-addressed load or store per cycle over a valid/ready request channel and returns an in-order response after a configurable read latency. Supports byte/half/word (and dword when 64-bit) accesses with lane masking, sign/zero extension of loads, and error responses for misaligned or out-of-range addresses. Sits behind the LSU as the simulation-side data memory.

---
 rtl/ls_dmem.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ls_dmem.sv
// Load/store data memory: byte-addressed requests with lane masking, load
// extension and misalignment/range errors; in-order responses after RD_LAT cycles.
module ls_dmem #(
  parameter int                ADDR_W = 32,
  parameter int                DATA_W = 32,
  parameter int                DEPTH  = 256,
  parameter int                RD_LAT = 1,
  parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int NBYTES = DATA_W / 8;
  localparam int LANE_W = $clog2(NBYTES);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int HI_W   = ADDR_W - LANE_W - IDX_W;
  localparam int LAST   = RD_LAT - 1;

  typedef struct packed {
    logic              is_load;
    logic [1:0]        size;
    logic              sgn;
    logic [LANE_W-1:0] lane;
    logic              err;
    logic [DATA_W-1:0] word;
  } stage_t;

  // Access must start on a lane that is a multiple of its own size.
  function automatic logic misaligned(input logic [LANE_W-1:0] ln,
                                      input logic [1:0]        sz);
    logic bad;
    case (sz)
      2'd0:    bad = 1'b0;
      2'd1:    bad = ln[0];
      2'd2:    bad = |ln[1:0];
      default: bad = |ln;
    endcase
    return bad;
  endfunction

  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] w,
                                                 input logic [LANE_W-1:0] ln,
                                                 input logic [1:0]        sz,
                                                 input logic              sg);
    logic [DATA_W-1:0] s;
    logic [DATA_W-1:0] m;
    logic              msb;
    s = w >> {ln, 3'b000};
    case (sz)
      2'd0: begin
        m   = {DATA_W{1'b1}} >> (DATA_W - 8);
        msb = s[7];
      end
      2'd1: begin
        m   = {DATA_W{1'b1}} >> (DATA_W - 16);
        msb = s[15];
      end
      2'd2: begin
        m   = {DATA_W{1'b1}} >> (DATA_W - 32);
        msb = s[31];
      end
      default: begin
        m   = {DATA_W{1'b1}};
        msb = s[DATA_W-1];
      end
    endcase
    if (sg && msb) return s | ~m;
    return s & m;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] off;
  logic [IDX_W-1:0]  idx;
  logic [LANE_W-1:0] lane;
  logic              below_base;
  logic              out_of_range;
  logic              size_bad;
  logic              req_err;
  logic              stall;
  logic              accept;
  logic              we;
  logic [NBYTES-1:0] bmask;
  logic [DATA_W-1:0] wsh;
  logic [DATA_W-1:0] rd_word;

  logic [RD_LAT-1:0] vld_q;
  stage_t            stg_d;
  stage_t            stg_q [RD_LAT];

  // Request decode: offset from BASE split into word index and byte lane.
  assign off        = req_addr - BASE;
  assign idx        = off[LANE_W +: IDX_W];
  assign lane       = off[LANE_W-1:0];
  assign below_base = (req_addr < BASE);

  generate
    if (HI_W > 0) begin : g_hi
      assign out_of_range = |off[ADDR_W-1 -: HI_W];
    end else begin : g_nohi
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign size_bad = (req_size == 2'd3) && (DATA_W == 32);
  assign req_err  = below_base || out_of_range || size_bad || misaligned(lane, req_size);

  assign stall     = resp_valid && !resp_ready;
  assign req_ready = !stall && !reset;
  assign accept    = req_valid && req_ready;
  assign we        = accept && req_wen && !req_err;

  always_comb begin
    bmask = '0;
    for (int b = 0; b < NBYTES; b++) begin
      bmask[b] = (b >= int'(lane)) && (b < int'(lane) + (1 << int'(req_size)));
    end
  end

  assign wsh     = req_wdata << {lane, 3'b000};
  assign rd_word = mem[idx];

  // Stores commit at the acceptance edge, so a load issued next cycle sees them.
  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (bmask[b]) mem[idx][8*b +: 8] <= wsh[8*b +: 8];
      end
    end
  end

  always_comb begin
    stg_d         = '0;
    stg_d.is_load = !req_wen;
    stg_d.size    = req_size;
    stg_d.sgn     = req_signed;
    stg_d.lane    = lane;
    stg_d.err     = req_err;
    stg_d.word    = rd_word;
  end

  // Response pipeline: all stages advance together and hold on stall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
    end else if (!stall) begin
      vld_q[0] <= accept;
      for (int i = 1; i < RD_LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (!stall) begin
      stg_q[0] <= stg_d;
      for (int i = 1; i < RD_LAT; i++) stg_q[i] <= stg_q[i-1];
    end
  end

  // Output stage: stores and errors return zero data.
  assign resp_valid = vld_q[LAST];
  assign resp_err   = resp_valid && stg_q[LAST].err;
  assign resp_rdata = (resp_valid && stg_q[LAST].is_load && !stg_q[LAST].err)
                      ? load_ext(stg_q[LAST].word, stg_q[LAST].lane,
                                 stg_q[LAST].size, stg_q[LAST].sgn)
                      : '0;

endmodule
